ce_rate_monitor: RTL
====================

# ce_rate_monitor

Measures the clock-enable pulse trains that drive the CPU, video and SDRAM paths, checking both their rate and their spacing. Each selected enable is sampled against the 1 MHz reference tick. The block reports pulses per measurement window (kHz when the window is 1000 µs) and the minimum and maximum pulse spacing, and raises sticky errors for wrong spacing or a stalled train. It sits beside the clock-enable generator and feeds the OSD turbo-speed readout and debug status.

## Interface
- SYS_MHZ, 64, system clock frequency in MHz; informational, sizes nothing.
- WINDOW_US, 1000, measurement window length in reference ticks (1..65535).
- EDGE_MODE, 0, 0 = count every cycle ce_in is high; 1 = count rising edges of ce_in only.

Ports (clock and reset first):
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- ce_in  in  1  enable under test.
- ce_ref  in  1  1 µs reference tick, single-cycle pulse.
- enable  in  1  measurement run; low forces IDLE.
- expected_period  in  7  expected spacing in clk cycles; 0 disables spacing check.
- clear_err  in  1  clears sticky error flags.
- rate  out  16  pulses counted in the last completed window.
- rate_valid  out  1  one-cycle strobe when rate, min_period and max_period update.
- min_period  out  7  smallest spacing seen in the last window.
- max_period  out  7  largest spacing seen in the last window.
- period_err  out  1  sticky: a spacing differed from expected_period.
- stuck_err  out  1  sticky: spacing counter saturated at 127.

## Operation
- Reset value of every output is 0. Internal state after reset: IDLE, all counters 0, min_acc = 127, max_acc = 0.
- Pulse event:
  - EDGE_MODE 0: pulse = ce_in.
  - EDGE_MODE 1: pulse = ce_in & ~ce_in_d. ce_in_d resets to 0.
- FSM states and transitions:
  - IDLE: waits for enable.
  - ARM: waits for the first ce_ref so windows are tick-aligned. Goes to MEASURE on that tick.
  - MEASURE: on each ce_ref, increments tick_cnt. When tick_cnt reaches WINDOW_US on a ce_ref, goes to PUBLISH.
  - PUBLISH: lasts one cycle, then returns to MEASURE.
  - enable low in any state returns to IDLE next cycle and clears the accumulators. Published outputs hold their values.
- Pulse counting:
  - pulse_cnt counts pulses in MEASURE, including a pulse on the window-closing ce_ref cycle.
  - pulse_cnt saturates at 0xFFFF.
  - A pulse during the PUBLISH cycle counts toward the new window.
- Spacing measurement:
  - gap_cnt increments every cycle outside IDLE and saturates at 127.
  - On a pulse: spacing = gap_cnt + 1, saturated at 127. gap_cnt then resets to 0.
  - The first pulse after ARM yields no spacing sample (has_prev = 0).
  - Each spacing sample updates min_acc and max_acc.
  - If expected_period ≠ 0 and spacing ≠ expected_period, period_err is set.
- stuck_err is set when gap_cnt reaches 127 and has_prev = 1.
- clear_err clears both sticky flags. If clear_err and a set condition occur in the same cycle, the set condition wins.
- PUBLISH:
  - Loads rate ← pulse_cnt, min_period ← min_acc, max_period ← max_acc.
  - Reloads min_acc = 127, max_acc = 0, pulse_cnt = 0, tick_cnt = 0.
  - A window with no spacing sample publishes min_period 127 and max_period 0.

## Timing
- rate_valid is high in the cycle after the window-closing ce_ref. Outputs update on that same edge.
- Error flags assert one cycle after the offending pulse or saturation.
- Window length is exactly WINDOW_US ce_ref ticks. It does not depend on SYS_MHZ.
- Mid-window reset: asynchronous return to the reset state; no partial publish.
- Toggling enable restarts the window alignment through ARM.

## Structure
- Shared package ce_pkg holds:
  - the state enum typedef {IDLE, ARM, MEASURE, PUBLISH};
  - localparam GAP_MAX = 7'd127;
  - a rate-width localparam RATE_W = 16.
- One sub-module is natural: ce_gap_meter. It covers the edge detect, gap_cnt, has_prev, min/max accumulators and error flags. The top holds the FSM and the window counters.

## Test plan
- WINDOW_US = 10, EDGE_MODE 1, ce_ref every 64 clk, ce_in one-cycle pulse every 16 clk, expected_period 16 → rate = 40, min_period = max_period = 16, rate_valid every 640 clk, no errors.
- Same, one pulse delayed 3 clk → min_period 13, max_period 19, period_err set. Assert clear_err → period_err returns to 0 next cycle.
- EDGE_MODE 0, ce_in high 8 of every 16 clk (cpu_ce_p at 4 MHz) → rate = 320 per 10 µs window, min_period 1, max_period 9.
- Stop ce_in after several pulses → stuck_err set 127 clk after the last pulse. Next window publishes min_period 127, max_period 0.
- Pulse coincident with the closing ce_ref counts in the closing window. A pulse on the PUBLISH cycle counts in the next window, so published rate is 41 then 39.
- Assert reset mid-window, then drop enable → all outputs 0. Re-enable → first rate_valid arrives exactly WINDOW_US ticks after the first ce_ref.

Source files
------------

// File: rtl/ce_pkg.sv
// Shared types and constants for the clock-enable rate monitor.
package ce_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    PUBLISH = 2'd3
  } ce_state_e;

  // Spacing counter ceiling; also the "no sample seen" value of the minimum.
  localparam logic [6:0] GAP_MAX = 7'd127;

  // Width of the per-window pulse count.
  localparam int RATE_W = 16;

  // Saturation value of the per-window pulse count.
  localparam logic [RATE_W-1:0] RATE_MAX = 16'hFFFF;

  // Saturating increment for the 7-bit spacing domain.
  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    logic [6:0] r;
    if (v == GAP_MAX) begin
      r = GAP_MAX;
    end else begin
      r = v + 7'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ce_gap_meter.sv
// Pulse qualification, inter-pulse spacing measurement, min/max accumulation
// and the sticky spacing / stall error flags.
module ce_gap_meter
  import ce_pkg::*;
#(
  parameter int EDGE_MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_in,
  input  logic       active,
  input  logic       publish,
  input  logic [6:0] expected_period,
  input  logic       clear_err,
  output logic       pulse,
  output logic [6:0] min_merge,
  output logic [6:0] max_merge,
  output logic       period_err,
  output logic       stuck_err
);

  logic       ce_in_d_r;
  logic       has_prev_r;
  logic       period_err_r;
  logic       stuck_err_r;
  logic [6:0] gap_cnt_r;
  logic [6:0] min_acc_r;
  logic [6:0] max_acc_r;

  logic       pulse_s;
  logic       sample_s;
  logic       period_set_s;
  logic       stuck_set_s;
  logic [6:0] spacing_s;
  logic [6:0] min_merge_s;
  logic [6:0] max_merge_s;

  // Qualify the pulse and fold the current spacing sample into min/max.
  always_comb begin
    pulse_s      = 1'b0;
    sample_s     = 1'b0;
    period_set_s = 1'b0;
    stuck_set_s  = 1'b0;
    spacing_s    = sat_inc7(gap_cnt_r);
    min_merge_s  = min_acc_r;
    max_merge_s  = max_acc_r;

    if (EDGE_MODE != 0) begin
      pulse_s = ce_in & ~ce_in_d_r;
    end else begin
      pulse_s = ce_in;
    end

    // The first pulse after arming only establishes a reference point.
    sample_s = active & pulse_s & has_prev_r;

    if (sample_s && (spacing_s < min_acc_r)) begin
      min_merge_s = spacing_s;
    end else begin
      min_merge_s = min_acc_r;
    end

    if (sample_s && (spacing_s > max_acc_r)) begin
      max_merge_s = spacing_s;
    end else begin
      max_merge_s = max_acc_r;
    end

    if (sample_s && (expected_period != 7'd0) && (spacing_s != expected_period)) begin
      period_set_s = 1'b1;
    end else begin
      period_set_s = 1'b0;
    end

    if (active && has_prev_r && (gap_cnt_r == GAP_MAX)) begin
      stuck_set_s = 1'b1;
    end else begin
      stuck_set_s = 1'b0;
    end
  end

  // Previous ce_in sample for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_in_d_r <= 1'b0;
    end else begin
      ce_in_d_r <= ce_in;
    end
  end

  // Cycles since the last pulse, and whether a reference pulse exists.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt_r  <= 7'd0;
      has_prev_r <= 1'b0;
    end else if (!active) begin
      gap_cnt_r  <= 7'd0;
      has_prev_r <= 1'b0;
    end else if (pulse_s) begin
      gap_cnt_r  <= 7'd0;
      has_prev_r <= 1'b1;
    end else begin
      gap_cnt_r  <= sat_inc7(gap_cnt_r);
      has_prev_r <= has_prev_r;
    end
  end

  // Per-window min/max accumulators, reloaded when a window is published.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_acc_r <= GAP_MAX;
      max_acc_r <= 7'd0;
    end else if (!active || publish) begin
      min_acc_r <= GAP_MAX;
      max_acc_r <= 7'd0;
    end else begin
      min_acc_r <= min_merge_s;
      max_acc_r <= max_merge_s;
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_err_r <= 1'b0;
      stuck_err_r  <= 1'b0;
    end else begin
      if (period_set_s) begin
        period_err_r <= 1'b1;
      end else if (clear_err) begin
        period_err_r <= 1'b0;
      end else begin
        period_err_r <= period_err_r;
      end
      if (stuck_set_s) begin
        stuck_err_r <= 1'b1;
      end else if (clear_err) begin
        stuck_err_r <= 1'b0;
      end else begin
        stuck_err_r <= stuck_err_r;
      end
    end
  end

  assign pulse      = pulse_s;
  assign min_merge  = min_merge_s;
  assign max_merge  = max_merge_s;
  assign period_err = period_err_r;
  assign stuck_err  = stuck_err_r;

endmodule

// File: rtl/ce_rate_monitor.sv
// Clock-enable rate and spacing monitor: counts qualified ce_in pulses over a
// window of reference ticks and publishes count plus min/max spacing.
module ce_rate_monitor
  import ce_pkg::*;
#(
  parameter int SYS_MHZ   = 64,
  parameter int WINDOW_US = 1000,
  parameter int EDGE_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_in,
  input  logic              ce_ref,
  input  logic              enable,
  input  logic [6:0]        expected_period,
  input  logic              clear_err,
  output logic [RATE_W-1:0] rate,
  output logic              rate_valid,
  output logic [6:0]        min_period,
  output logic [6:0]        max_period,
  output logic              period_err,
  output logic              stuck_err
);

  // Window length and clock frequency must be representable and non-zero.
  if ((WINDOW_US < 1) || (WINDOW_US > 65535) || (SYS_MHZ < 1)) begin : g_bad_param
    $error("ce_rate_monitor: WINDOW_US must be 1..65535 and SYS_MHZ positive");
  end

  localparam logic [15:0] WIN_LAST = 16'(WINDOW_US - 1);

  ce_state_e         state_r;
  ce_state_e         next_state_s;
  logic [15:0]       tick_cnt_r;
  logic [RATE_W-1:0] pulse_cnt_r;
  logic [RATE_W-1:0] cnt_merge_s;
  logic              active_s;
  logic              run_s;
  logic              close_s;
  logic              pulse_s;
  logic [6:0]        min_merge_s;
  logic [6:0]        max_merge_s;

  logic [RATE_W-1:0] rate_r;
  logic              rate_valid_r;
  logic [6:0]        min_period_r;
  logic [6:0]        max_period_r;

  ce_gap_meter #(
    .EDGE_MODE(EDGE_MODE)
  ) u_gap (
    .clk             (clk),
    .reset           (reset),
    .ce_in           (ce_in),
    .active          (active_s),
    .publish         (close_s),
    .expected_period (expected_period),
    .clear_err       (clear_err),
    .pulse           (pulse_s),
    .min_merge       (min_merge_s),
    .max_merge       (max_merge_s),
    .period_err      (period_err),
    .stuck_err       (stuck_err)
  );

  // Sequencer next state and window-close detection.
  always_comb begin
    next_state_s = state_r;
    active_s     = enable & (state_r != IDLE);
    run_s        = enable & ((state_r == MEASURE) | (state_r == PUBLISH));
    close_s      = run_s & ce_ref & (tick_cnt_r == WIN_LAST);
    cnt_merge_s  = pulse_cnt_r;

    if (run_s && pulse_s && (pulse_cnt_r != RATE_MAX)) begin
      cnt_merge_s = pulse_cnt_r + 16'd1;
    end else begin
      cnt_merge_s = pulse_cnt_r;
    end

    if (!enable) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = ARM;
        ARM: begin
          if (ce_ref) begin
            next_state_s = MEASURE;
          end else begin
            next_state_s = ARM;
          end
        end
        MEASURE: begin
          if (close_s) begin
            next_state_s = PUBLISH;
          end else begin
            next_state_s = MEASURE;
          end
        end
        PUBLISH: begin
          if (close_s) begin
            next_state_s = PUBLISH;
          end else begin
            next_state_s = MEASURE;
          end
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Reference ticks and pulses counted within the current window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_r  <= 16'd0;
      pulse_cnt_r <= 16'd0;
    end else if (!active_s || close_s) begin
      tick_cnt_r  <= 16'd0;
      pulse_cnt_r <= 16'd0;
    end else begin
      if (run_s && ce_ref) begin
        tick_cnt_r <= tick_cnt_r + 16'd1;
      end else begin
        tick_cnt_r <= tick_cnt_r;
      end
      pulse_cnt_r <= cnt_merge_s;
    end
  end

  // Published results; held between windows and across enable drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_r       <= 16'd0;
      rate_valid_r <= 1'b0;
      min_period_r <= 7'd0;
      max_period_r <= 7'd0;
    end else if (close_s) begin
      rate_r       <= cnt_merge_s;
      rate_valid_r <= 1'b1;
      min_period_r <= min_merge_s;
      max_period_r <= max_merge_s;
    end else begin
      rate_r       <= rate_r;
      rate_valid_r <= 1'b0;
      min_period_r <= min_period_r;
      max_period_r <= max_period_r;
    end
  end

  assign rate       = rate_r;
  assign rate_valid = rate_valid_r;
  assign min_period = min_period_r;
  assign max_period = max_period_r;

endmodule
